master_writeback: RTL
=====================

// Module: master_writeback
// PURPOSE
//  Writeback stage directly downstream of the master ALU. Registers the ALU's Result/New_Flag/memory_enable
//  through a valid/ready pipeline slot, commits results to the 16x32 register file and the NZCV flag register,
//  and hands ADR/LDR/STR to the memory port. Register-file read ports and the flag register feed the ALU's Reg1/Reg2/Flag.
// PARAMETERS
//  NREGS     16  register count (index width = $clog2(NREGS) = 4)
//  DW        32  data width
//  MEM_TOUT  15  cycles to wait for mem_ack before abort (4-bit counter)
// PORTS
//  clk          in   1   system clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  in_valid     in   1   ALU output valid this cycle
//  in_ready     out  1   stage can accept (slot empty or committing this cycle)
//  in_result    in   32  ALU Result (signed)
//  in_new_flag  in   4   ALU New_Flag {N,Z,C,V} = bits [3:0]
//  in_mem_en    in   1   ALU memory_enable (condition passed, writes allowed)
//  in_opcode    in   4   instruction opcode
//  in_s         in   1   S bit (update flags)
//  in_rd        in   4   destination register index
//  rs1_addr     in   4   read port A index
//  rs1_data     out  32  read port A data -> ALU Reg1
//  rs2_addr     in   4   read port B index
//  rs2_data     out  32  read port B data -> ALU Reg2
//  flags        out  4   committed NZCV -> ALU Flag
//  mem_req      out  1   memory request (held until mem_ack or timeout)
//  mem_op       out  2   01 ADR, 10 LDR, 11 STR
//  mem_addr     out  32  address (= latched result)
//  mem_ack      in   1   memory completion strobe
//  mem_rdata    in   32  load data, valid with mem_ack
//  mem_err      out  1   sticky timeout flag, cleared only by reset
// BEHAVIOUR
//  Reset: all regs 0, flags 0000, slot empty, state IDLE, mem_req 0, mem_op 00, mem_err 0, in_ready 1.
//  Accept: transfer when in_valid && in_ready; fields latched on that edge. in_ready = (state==IDLE) &&
//   (!slot_v || commit-this-cycle). Latency: regfile/flags visible on read ports 1 cycle after accept.
//  FSM IDLE: slot_v with opcode 0000-1010, in_mem_en=1 -> commit rd <= result (MOVn/MOV included);
//   opcode 1011 CMP -> flags only, no reg write; opcode 1100/1101/1110 with mem_en -> MEM_WAIT;
//   in_mem_en=0 (condition failed) -> slot retired, no writes; opcode 1111 -> retired, no effect.
//  Flags: update flags<=new_flag when CMP, or when in_s=1 on opcodes 0000-0101,1000-1010. MOV/MOVn never.
//  MEM_WAIT: mem_req=1, mem_op/mem_addr stable; on mem_ack: LDR writes rd<=mem_rdata, ADR writes rd<=result,
//   STR no write; -> IDLE, slot retired. Counter increments each wait cycle; at MEM_TOUT without ack ->
//   mem_err=1, slot retired, no write, -> IDLE. mem_ack in IDLE ignored.
//  Read bypass: rsX_data returns the value being committed this cycle if rsX_addr==commit index (write-first).
//  Simultaneous accept+commit allowed in IDLE (full throughput, 1 instr/cycle for non-memory ops).
//  Reset mid-MEM_WAIT: request dropped immediately (async), no write.
// STRUCTURE
//  Shared package master_pkg: opcode localparams (OP_ADD..OP_STR), flag bit indices (FLG_N=3,FLG_Z=2,FLG_C=1,
//   FLG_V=0), mem_op encodings, FSM state encodings. One sub-module master_regfile (16x32, 2 async read,
//   1 sync write, write-first bypass); FSM, slot and flag reg in top.
// TESTING
//  1 reset, in ADD rd=3 result=0x0000_0005 mem_en=1 s=0 -> r3=5 next cycle, flags stay 0000.
//  2 SUB s=1 result=0 new_flag=0100 rd=2 -> r2=0, flags=0100; following CMP new_flag=1000 -> flags=1000, r2 unchanged.
//  3 ADD rd=4 mem_en=0 result=0xDEAD -> r4 unchanged, flags unchanged, in_ready stays 1.
//  4 LDR result=0x40 rd=7; ack after 3 cycles with rdata=0x1234_5678 -> mem_req high 3 cycles, mem_op=10,
//    mem_addr=0x40, in_ready=0 throughout, r7=0x1234_5678.
//  5 STR no ack for 15 cycles -> mem_err=1, mem_req drops, no reg write, in_ready returns 1.
//  6 back-to-back MOV rd=1 val=9 then read rs1_addr=1 in commit cycle -> rs1_data=9 (bypass); assert rst_n
//    low during MEM_WAIT -> mem_req=0 same cycle, all regs 0.

Source files
------------

// File: rtl/master_pkg.sv
// Shared definitions for the master writeback stage: opcodes, flag bits, memory-op codes, FSM states.
package master_pkg;

    localparam int unsigned NREGS    = 16;
    localparam int unsigned DW       = 32;
    localparam int unsigned AW       = $clog2(NREGS);
    localparam int unsigned MEM_TOUT = 15;
    localparam int unsigned CW       = 4;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_ORR = 4'b0011;
    localparam logic [3:0] OP_EOR = 4'b0100;
    localparam logic [3:0] OP_RSB = 4'b0101;
    localparam logic [3:0] OP_MOV = 4'b0110;
    localparam logic [3:0] OP_MVN = 4'b0111;
    localparam logic [3:0] OP_LSL = 4'b1000;
    localparam logic [3:0] OP_LSR = 4'b1001;
    localparam logic [3:0] OP_ASR = 4'b1010;
    localparam logic [3:0] OP_CMP = 4'b1011;
    localparam logic [3:0] OP_ADR = 4'b1100;
    localparam logic [3:0] OP_LDR = 4'b1101;
    localparam logic [3:0] OP_STR = 4'b1110;
    localparam logic [3:0] OP_NOP = 4'b1111;

    localparam int unsigned FLG_N = 3;
    localparam int unsigned FLG_Z = 2;
    localparam int unsigned FLG_C = 1;
    localparam int unsigned FLG_V = 0;

    localparam logic [1:0] MEM_NONE = 2'b00;
    localparam logic [1:0] MEM_ADR  = 2'b01;
    localparam logic [1:0] MEM_LDR  = 2'b10;
    localparam logic [1:0] MEM_STR  = 2'b11;

    typedef enum logic [0:0] {StIdle, StMemWait} wb_state_e;

    typedef struct packed {
        logic [DW-1:0] result;
        logic [3:0]    new_flag;
        logic          mem_en;
        logic [3:0]    opcode;
        logic          s;
        logic [AW-1:0] rd;
    } slot_t;

    function automatic logic [1:0] mem_op_of(input logic [3:0] op);
        case (op)
            OP_ADR:  return MEM_ADR;
            OP_LDR:  return MEM_LDR;
            OP_STR:  return MEM_STR;
            default: return MEM_NONE;
        endcase
    endfunction

    // Data-processing ops that honour the S bit; MOV/MVN never touch flags.
    function automatic logic sets_flags_on_s(input logic [3:0] op);
        return (op <= OP_RSB) || ((op >= OP_LSL) && (op <= OP_ASR));
    endfunction

endpackage

// File: rtl/master_writeback_if.sv
// ALU-to-writeback handshake, register read ports and memory port bundled for the writeback stage.
interface master_writeback_if;
    import master_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_result;
    logic [3:0]    in_new_flag;
    logic          in_mem_en;
    logic [3:0]    in_opcode;
    logic          in_s;
    logic [AW-1:0] in_rd;
    logic [AW-1:0] rs1_addr;
    logic [DW-1:0] rs1_data;
    logic [AW-1:0] rs2_addr;
    logic [DW-1:0] rs2_data;
    logic [3:0]    flags;
    logic          mem_req;
    logic [1:0]    mem_op;
    logic [DW-1:0] mem_addr;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          mem_err;

    modport master (
        output in_valid, in_result, in_new_flag, in_mem_en, in_opcode, in_s, in_rd,
        output rs1_addr, rs2_addr, mem_ack, mem_rdata,
        input  in_ready, rs1_data, rs2_data, flags, mem_req, mem_op, mem_addr, mem_err
    );

    modport slave (
        input  in_valid, in_result, in_new_flag, in_mem_en, in_opcode, in_s, in_rd,
        input  rs1_addr, rs2_addr, mem_ack, mem_rdata,
        output in_ready, rs1_data, rs2_data, flags, mem_req, mem_op, mem_addr, mem_err
    );

endinterface

// File: rtl/master_regfile.sv
// 16x32 register file: two asynchronous read ports, one synchronous write port, write-first bypass.
module master_regfile
    import master_pkg::*;
#(
    parameter int unsigned NRegs = NREGS,
    parameter int unsigned Dw    = DW
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [$clog2(NRegs)-1:0] waddr,
    input  logic [Dw-1:0]            wdata,
    input  logic [$clog2(NRegs)-1:0] raddr_a,
    output logic [Dw-1:0]            rdata_a,
    input  logic [$clog2(NRegs)-1:0] raddr_b,
    output logic [Dw-1:0]            rdata_b
);

    logic [Dw-1:0] mem_q [NRegs];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NRegs; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_a = (we && (waddr == raddr_a)) ? wdata : mem_q[raddr_a];
    assign rdata_b = (we && (waddr == raddr_b)) ? wdata : mem_q[raddr_b];

endmodule

// File: rtl/master_writeback.sv
// Writeback stage: one-entry slot, commit FSM with memory wait/timeout, NZCV register and regfile.
module master_writeback
    import master_pkg::*;
(
    input logic               clk,
    input logic               rst_n,
    master_writeback_if.slave bus
);

    wb_state_e     state;
    slot_t         slot;
    logic          slot_v;
    logic [3:0]    flags_q;
    logic [CW-1:0] wait_cnt;
    logic          mem_req_q;
    logic [1:0]    mem_op_q;
    logic [DW-1:0] mem_addr_q;
    logic          mem_err_q;

    logic          is_mem;
    logic          retire_idle;
    logic          in_ready;
    logic          accept;
    logic          flag_we;
    logic          rf_we;
    logic [DW-1:0] rf_wdata;

    always_comb begin
        is_mem      = slot.mem_en && (mem_op_of(slot.opcode) != MEM_NONE);
        retire_idle = (state == StIdle) && slot_v && !is_mem;
        in_ready    = (state == StIdle) && (!slot_v || retire_idle);
        accept      = bus.in_valid && in_ready;
        flag_we     = retire_idle && slot.mem_en &&
                      ((slot.opcode == OP_CMP) || (slot.s && sets_flags_on_s(slot.opcode)));
        rf_we       = 1'b0;
        rf_wdata    = slot.result;
        if (retire_idle && slot.mem_en && (slot.opcode <= OP_ASR)) begin
            rf_we = 1'b1;
        end
        if ((state == StMemWait) && bus.mem_ack) begin
            if (slot.opcode == OP_LDR) begin
                rf_we    = 1'b1;
                rf_wdata = bus.mem_rdata;
            end else if (slot.opcode == OP_ADR) begin
                rf_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            slot       <= '0;
            slot_v     <= 1'b0;
            flags_q    <= '0;
            wait_cnt   <= '0;
            mem_req_q  <= 1'b0;
            mem_op_q   <= MEM_NONE;
            mem_addr_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            if (accept) begin
                slot_v <= 1'b1;
                slot   <= '{result:   bus.in_result,   new_flag: bus.in_new_flag,
                            mem_en:   bus.in_mem_en,   opcode:   bus.in_opcode,
                            s:        bus.in_s,        rd:       bus.in_rd};
            end else if (retire_idle) begin
                slot_v <= 1'b0;
            end
            if (flag_we) begin
                flags_q <= slot.new_flag;
            end
            case (state)
                StIdle: begin
                    if (slot_v && is_mem) begin
                        state      <= StMemWait;
                        mem_req_q  <= 1'b1;
                        mem_op_q   <= mem_op_of(slot.opcode);
                        mem_addr_q <= slot.result;
                        wait_cnt   <= '0;
                    end
                end
                StMemWait: begin
                    // The MEM_TOUT-th unacknowledged wait cycle aborts the access.
                    if (bus.mem_ack || (wait_cnt == CW'(MEM_TOUT - 1))) begin
                        state     <= StIdle;
                        slot_v    <= 1'b0;
                        mem_req_q <= 1'b0;
                        mem_op_q  <= MEM_NONE;
                        if (!bus.mem_ack) begin
                            mem_err_q <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    master_regfile #(
        .NRegs (NREGS),
        .Dw    (DW)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (rf_we),
        .waddr   (slot.rd),
        .wdata   (rf_wdata),
        .raddr_a (bus.rs1_addr),
        .rdata_a (bus.rs1_data),
        .raddr_b (bus.rs2_addr),
        .rdata_b (bus.rs2_data)
    );

    assign bus.in_ready = in_ready;
    assign bus.flags    = flags_q;
    assign bus.mem_req  = mem_req_q;
    assign bus.mem_op   = mem_op_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_err  = mem_err_q;

endmodule
